dmem_arbiter: RTL and testbench

//  Shares the single data_mem port between the CPU load/store path and a debug/DMA

---
 rtl/dmem_arbiter_if.sv | 45 ++++
 rtl/dmem_arbiter.sv | 97 +++++++++
 tb/tb_dmem_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - CPU, debug and data_mem signal bundle for dmem_arbiter
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              dbg_req;
  logic              dbg_we;
  logic              dbg_lock;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic [DATA_W-1:0] dbg_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_wr_enable;
  logic [DATA_W-1:0] mem_rd_data;
  logic [1:0]        owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rdata, cpu_stall,
    input  dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rdata,
    output mem_addr, mem_wr_data, mem_wr_enable,
    input  mem_rd_data,
    output owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rdata, cpu_stall,
    output dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rdata,
    input  mem_addr, mem_wr_data, mem_wr_enable,
    output mem_rd_data,
    input  owner
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data_mem port arbiter: CPU priority, debug anti-starvation and bounded lock bursts
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int LOCK_MAX     = 16
) (
  input logic          clk,
  input logic          rst,
  dmem_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_LIMIT);
  localparam logic [LW-1:0] LOCK_TOP   = LW'(LOCK_MAX);

  typedef enum logic [1:0] {NORMAL, LOCK, CPU_SLOT} state_t;

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic [LW-1:0] lock_cnt;
  logic          cpu_win;
  logic          dbg_win;
  logic          held;

  // Grants are combinational so the granted access completes in the request cycle.
  always_comb begin
    cpu_win = 1'b0;
    dbg_win = 1'b0;
    held    = 1'b0;
    if (rst) begin
      case (state)
        NORMAL: begin
          if (bus.dbg_req && (!bus.cpu_req || starve_cnt == STARVE_TOP))
            dbg_win = 1'b1;
          else if (bus.cpu_req)
            cpu_win = 1'b1;
        end
        LOCK: begin
          held    = 1'b1;
          dbg_win = bus.dbg_req;
        end
        CPU_SLOT: cpu_win = bus.cpu_req;
        default: ;
      endcase
    end
  end

  assign bus.cpu_gnt       = cpu_win;
  assign bus.dbg_gnt       = dbg_win;
  assign bus.cpu_stall     = rst & bus.cpu_req & ~cpu_win;
  assign bus.owner         = cpu_win ? 2'b01 : ((dbg_win || held) ? 2'b10 : 2'b00);
  assign bus.mem_addr      = cpu_win ? bus.cpu_addr  : (dbg_win ? bus.dbg_addr  : '0);
  assign bus.mem_wr_data   = cpu_win ? bus.cpu_wdata : (dbg_win ? bus.dbg_wdata : '0);
  assign bus.mem_wr_enable = (cpu_win & bus.cpu_we) | (dbg_win & bus.dbg_we);
  assign bus.cpu_rdata     = (cpu_win && !bus.cpu_we) ? bus.mem_rd_data : '0;
  assign bus.dbg_rdata     = (dbg_win && !bus.dbg_we) ? bus.mem_rd_data : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= NORMAL;
      starve_cnt <= '0;
      lock_cnt   <= '0;
    end else begin
      if (bus.dbg_req && !dbg_win)
        starve_cnt <= (starve_cnt == STARVE_TOP) ? starve_cnt : starve_cnt + 1'b1;
      else
        starve_cnt <= '0;

      case (state)
        NORMAL: begin
          if (dbg_win && bus.dbg_lock) begin
            state    <= LOCK;
            lock_cnt <= LW'(1);
          end
        end
        LOCK: begin
          // Burst length bound wins over a still-asserted lock.
          if (lock_cnt == LOCK_TOP) begin
            state <= CPU_SLOT;
          end else if (!bus.dbg_lock) begin
            state    <= NORMAL;
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        CPU_SLOT: begin
          state    <= NORMAL;
          lock_cnt <= '0;
        end
        default: begin
          state    <= NORMAL;
          lock_cnt <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a behavioural data_mem
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic mem_clear;
  logic [63:0] mem [0:255];

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(64)) bus ();

  dmem_arbiter #(.STARVE_LIMIT(4), .LOCK_MAX(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Word 0 reads a non-zero pattern so idle/reset rdata gating is visible.
  assign bus.mem_rd_data = (bus.mem_addr[10:3] == 8'd0) ? 64'h777 : mem[bus.mem_addr[10:3]];

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (bus.mem_wr_enable) begin
      mem[bus.mem_addr[10:3]] <= bus.mem_wr_data;
    end
  end

  typedef struct packed {
    logic        cg;
    logic        cs;
    logic        dg;
    logic [1:0]  own;
    logic        we;
    logic [31:0] addr;
    logic [63:0] wd;
    logic [63:0] crd;
    logic [63:0] drd;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    total = 0;
  int    bad   = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        exp_t  e;
        exp_t  a;
        string nm;
        e  = q.pop_front();
        nm = nq.pop_front();
        a  = '{bus.cpu_gnt, bus.cpu_stall, bus.dbg_gnt, bus.owner, bus.mem_wr_enable,
               bus.mem_addr, bus.mem_wr_data, bus.cpu_rdata, bus.dbg_rdata};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL %s: got cg=%b cs=%b dg=%b own=%b we=%b addr=%h wd=%h crd=%h drd=%h want cg=%b cs=%b dg=%b own=%b we=%b addr=%h wd=%h crd=%h drd=%h",
                   nm, a.cg, a.cs, a.dg, a.own, a.we, a.addr, a.wd, a.crd, a.drd,
                   e.cg, e.cs, e.dg, e.own, e.we, e.addr, e.wd, e.crd, e.drd);
        end
      end
    end
  end

  task automatic drive(input logic r, input logic cr, input logic cw, input logic [31:0] ca,
                       input logic [63:0] cd, input logic dr, input logic dw, input logic dl,
                       input logic [31:0] da, input logic [63:0] dd);
    rst           = r;
    bus.cpu_req   = cr;
    bus.cpu_we    = cw;
    bus.cpu_addr  = ca;
    bus.cpu_wdata = cd;
    bus.dbg_req   = dr;
    bus.dbg_we    = dw;
    bus.dbg_lock  = dl;
    bus.dbg_addr  = da;
    bus.dbg_wdata = dd;
  endtask

  task automatic ex(input string nm, input logic cg, input logic cs, input logic dg,
                    input logic [1:0] own, input logic we, input logic [31:0] addr,
                    input logic [63:0] wd, input logic [63:0] crd, input logic [63:0] drd);
    q.push_back('{cg, cs, dg, own, we, addr, wd, crd, drd});
    nq.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] da;
    mem_clear = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    mem_clear = 1'b0;

    // Reset holds everything off even with both requesters active.
    repeat (2) begin
      drive(0, 1, 1, 'h10, 'hAB, 1, 1, 1, 'h20, 'h1);
      ex("reset", 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    end

    drive(1, 1, 1, 'h10, 'hAB, 0, 0, 0, 0, 0);
    ex("cpu_store", 1, 0, 0, 2'b01, 1, 'h10, 'hAB, 0, 0);
    drive(1, 1, 0, 'h10, 0, 0, 0, 0, 0, 0);
    ex("cpu_load", 1, 0, 0, 2'b01, 0, 'h10, 0, 'hAB, 0);

    for (int k = 1; k <= 10; k++) begin
      drive(1, 1, 0, 'h10, 0, 1, 1, 0, 'h18, 'h55);
      if (k % 5 == 0) ex("contend_dbg", 0, 1, 1, 2'b10, 1, 'h18, 'h55, 0, 0);
      else            ex("contend_cpu", 1, 0, 0, 2'b01, 0, 'h10, 0, 'hAB, 0);
    end

    drive(1, 0, 0, 0, 0, 1, 1, 1, 'h20, 'h100);
    ex("lock_enter", 0, 0, 1, 2'b10, 1, 'h20, 'h100, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      da = 32'h20 + 32'(8 * (i % 4));
      drive(1, 1, 0, 'h10, 0, 1, 1, 1, da, 64'h100 + 64'(i));
      ex("lock_hold", 0, 1, 1, 2'b10, 1, da, 64'h100 + 64'(i), 0, 0);
    end
    drive(1, 1, 0, 'h10, 0, 1, 1, 1, 'h28, 'h1FF);
    ex("lock_cpu_slot", 1, 0, 0, 2'b01, 0, 'h10, 0, 'hAB, 0);
    drive(1, 0, 0, 0, 0, 1, 1, 1, 'h30, 'h200);
    ex("lock_reenter", 0, 0, 1, 2'b10, 1, 'h30, 'h200, 0, 0);

    repeat (2) begin
      drive(1, 1, 0, 'h10, 0, 1, 1, 1, 'h30, 'h201);
      ex("release_hold", 0, 1, 1, 2'b10, 1, 'h30, 'h201, 0, 0);
    end
    drive(1, 1, 0, 'h10, 0, 0, 0, 0, 0, 0);
    ex("release_drop", 0, 1, 0, 2'b10, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 'h10, 0, 0, 0, 0, 0, 0);
    ex("release_cpu", 1, 0, 0, 2'b01, 0, 'h10, 0, 'hAB, 0);

    drive(1, 0, 0, 0, 0, 1, 0, 0, 'h38, 0);
    ex("dbg_read38", 0, 0, 1, 2'b10, 0, 'h38, 0, 0, 'h10F);
    drive(1, 0, 0, 0, 0, 1, 0, 0, 'h30, 0);
    ex("dbg_read30", 0, 0, 1, 2'b10, 0, 'h30, 0, 0, 'h201);
    drive(1, 0, 0, 0, 0, 1, 0, 0, 'h18, 0);
    ex("dbg_read18", 0, 0, 1, 2'b10, 0, 'h18, 0, 0, 'h55);

    drive(1, 0, 0, 0, 0, 1, 1, 1, 'h40, 'h300);
    ex("rstlock_enter", 0, 0, 1, 2'b10, 1, 'h40, 'h300, 0, 0);
    drive(1, 1, 0, 'h50, 0, 1, 1, 1, 'h48, 'h301);
    ex("rstlock_hold", 0, 1, 1, 2'b10, 1, 'h48, 'h301, 0, 0);
    drive(0, 1, 0, 'h50, 0, 1, 1, 1, 'h50, 'h302);
    ex("rstlock_reset", 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      drive(1, 1, 0, 'h50, 0, 1, 1, 0, 'h58, 'h303);
      if (k == 5) ex("rstlock_dbg", 0, 1, 1, 2'b10, 1, 'h58, 'h303, 0, 0);
      else        ex("rstlock_cpu", 1, 0, 0, 2'b01, 0, 'h50, 0, 0, 0);
    end

    repeat (2) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      ex("idle", 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    end

    for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge clk);
    if (q.size() > 0) begin
      bad++;
      total++;
      $display("FAIL drain: pending=%0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
